reg_read_issue: RTL and testbench
=================================

# reg_read_issue

Operand fetch and issue stage directly upstream of the `alu` block. It holds the 32-entry architectural register file and accepts decoded instructions through a valid/ready handshake. It reads the two source operands, optionally substitutes a sign-extended immediate for the second operand, and registers `ALU_OP`, `rs` and `rt` so they drive the ALU inputs. It also takes the write-back port that returns `alu_result` to the register file.

## Interface
- `DATA_W`, 32, operand/register width
- `ADDR_W`, 5, register address width (2^ADDR_W entries)
- `OP_W`, 3, ALU opcode width
- `IMM_W`, 16, immediate width, sign-extended to DATA_W

Ports:
- `CLOCK_50`  in  1  sole clock, rising edge
- `reset`  in  1  synchronous, active-high
- `in_valid`  in  1  decoded instruction present
- `in_ready`  out  1  stage can accept this cycle
- `in_op`  in  OP_W  ALU opcode
- `in_rs_addr`  in  ADDR_W  first source register
- `in_rt_addr`  in  ADDR_W  second source register
- `in_rd_addr`  in  ADDR_W  destination, passed through
- `in_imm`  in  IMM_W  immediate
- `in_use_imm`  in  1  1: rt operand = sign-extended `in_imm`
- `wb_en`  in  1  write-back enable
- `wb_addr`  in  ADDR_W  write-back register
- `wb_data`  in  DATA_W  write-back value
- `flush`  in  1  discard held and incoming instruction
- `out_valid`  out  1  ALU inputs valid
- `out_ready`  in  1  ALU/downstream consumes this cycle
- `ALU_OP`  out  OP_W  registered opcode to `alu`
- `rs`  out  DATA_W  registered first operand
- `rt`  out  DATA_W  registered second operand
- `out_rd_addr`  out  ADDR_W  registered destination

## Operation
- Register file: 2^ADDR_W x DATA_W. Entry 0 always reads 0; a write to address 0 is ignored.
- Write: on a rising edge with `wb_en`=1 and `wb_addr`!=0, `regs[wb_addr]` <= `wb_data`.
- Read: combinational from `in_rs_addr` / `in_rt_addr`, with bypass per Configuration.
- Output register: one entry.
  - `in_ready` = `!out_valid || out_ready` (combinational, pass-through when consumed).
  - Accept = `in_valid && in_ready && !flush`.
  - On accept: latch `in_op`, both operands, `in_rd_addr`; `out_valid` <= 1.
  - Else if `out_ready`: `out_valid` <= 0.
  - Else: hold all outputs unchanged.
- Operands are captured at accept. Later write-backs never modify a held entry; RAW hazards against in-flight results are resolved outside this block.
- `rt` select: `in_use_imm`=1 gives {sign-extended `in_imm`}, otherwise the register read.
- `flush`=1: `out_valid` <= 0 and any concurrent accept is dropped. The register-file write still occurs.
- States (implicit in `out_valid`): EMPTY (0), FULL (1). EMPTY->FULL on accept. FULL->FULL on accept while `out_ready`. FULL->EMPTY on `out_ready` without accept. Any state -> EMPTY on flush or reset.

## Timing
- Latency: 1 cycle from accept to `out_valid`. Throughput 1/cycle while `out_ready`=1.
- Reset values: `out_valid`=0, `ALU_OP`=0, `rs`=0, `rt`=0, `out_rd_addr`=0, all register entries 0. `in_ready`=1 in the cycle after reset deasserts.
- Reset mid-operation: a held entry is discarded and a same-cycle write-back is not performed.
- Simultaneous write-back and read of the same nonzero address in one cycle: governed by the bypass macro.
- Simultaneous `flush` and `reset`: reset dominates; the result is identical.

## Configuration
- `ISSUE_BYPASS_EN` defined: when `wb_en` && `wb_addr`==read address && address!=0, the read returns `wb_data` in the same cycle (write-through).
- Not defined: the read returns the pre-write contents. The new value is visible from the next cycle.

## Test plan
- Reset, then write r1=7 and r2=5. Issue op=3'b000, rs=r1, rt=r2 -> next cycle `out_valid`=1, `ALU_OP`=0, `rs`=7, `rt`=5.
- Write r0=0xFFFFFFFF, then issue rs=r0 -> `rs`=0.
- Issue with `in_use_imm`=1, `in_imm`=16'hFFFE -> `rt`=32'hFFFFFFFE. With `in_imm`=16'h0005 -> `rt`=5.
- Same cycle: `wb_en` r3=9 and issue rs=r3 (r3 previously 0). With `ISSUE_BYPASS_EN`: `rs`=9. Without: `rs`=0.
- Hold `out_ready`=0 with an entry held: `in_ready`=0 and outputs are stable for 5 cycles while r1 is overwritten to 100, `rs` stays 7. Raise `out_ready` and issue a new instruction -> it is accepted that cycle with no bubble.
- Assert `flush` while FULL with `in_valid`=1 -> next cycle `out_valid`=0. Assert `reset` while FULL -> `out_valid`=0 and r1 reads 0.

Source files
------------

// File: rtl/reg_read_issue.sv
// Operand fetch / issue stage feeding the ALU: 32-entry register file, one-entry output register.
// Build option: define ISSUE_BYPASS_EN to forward same-cycle write-back data to the read ports.
//
// state | meaning
// EMPTY | no instruction held, out_valid=0
// FULL  | ALU_OP/rs/rt/out_rd_addr hold a valid instruction, out_valid=1
module reg_read_issue #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int OP_W   = 3,
    parameter int IMM_W  = 16
) (
    input  logic              CLOCK_50,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [OP_W-1:0]   in_op,
    input  logic [ADDR_W-1:0] in_rs_addr,
    input  logic [ADDR_W-1:0] in_rt_addr,
    input  logic [ADDR_W-1:0] in_rd_addr,
    input  logic [IMM_W-1:0]  in_imm,
    input  logic              in_use_imm,
    input  logic              wb_en,
    input  logic [ADDR_W-1:0] wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [OP_W-1:0]   ALU_OP,
    output logic [DATA_W-1:0] rs,
    output logic [DATA_W-1:0] rt,
    output logic [ADDR_W-1:0] out_rd_addr
);

    localparam int NREGS = 2 ** ADDR_W;

    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

    state_t              state_q, state_d;
    logic [OP_W-1:0]     op_q, op_d;
    logic [DATA_W-1:0]   rs_q, rs_d;
    logic [DATA_W-1:0]   rt_q, rt_d;
    logic [ADDR_W-1:0]   rd_q, rd_d;
    logic [DATA_W-1:0]   regs_q [NREGS];

    logic [DATA_W-1:0]   rs_rd;
    logic [DATA_W-1:0]   rt_rd;
    logic [DATA_W-1:0]   imm_ext;
    logic                accept;

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
        end else if (wb_en && (wb_addr != '0)) begin
            regs_q[wb_addr] <= wb_data;
        end
    end

    // Entry 0 is hard-wired to zero regardless of what the array holds.
    function automatic logic [DATA_W-1:0] read_port(input logic [ADDR_W-1:0] addr);
        logic [DATA_W-1:0] val;
        val = '0;
        if (addr != '0) begin
`ifdef ISSUE_BYPASS_EN
            if (wb_en && (wb_addr == addr)) begin
                val = wb_data;
            end else begin
                val = regs_q[addr];
            end
`else
            val = regs_q[addr];
`endif
        end
        return val;
    endfunction

    always_comb begin
        rs_rd   = read_port(in_rs_addr);
        rt_rd   = read_port(in_rt_addr);
        imm_ext = {{(DATA_W-IMM_W){in_imm[IMM_W-1]}}, in_imm};
    end

    assign out_valid   = (state_q == FULL);
    assign in_ready    = !out_valid || out_ready;
    assign accept      = in_valid && in_ready && !flush;
    assign ALU_OP      = op_q;
    assign rs          = rs_q;
    assign rt          = rt_q;
    assign out_rd_addr = rd_q;

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        rs_d    = rs_q;
        rt_d    = rt_q;
        rd_d    = rd_q;
        if (flush) begin
            state_d = EMPTY;
        end else if (accept) begin
            state_d = FULL;
            op_d    = in_op;
            rs_d    = rs_rd;
            rt_d    = in_use_imm ? imm_ext : rt_rd;
            rd_d    = in_rd_addr;
        end else if (out_ready) begin
            state_d = EMPTY;
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state_q <= EMPTY;
            op_q    <= '0;
            rs_q    <= '0;
            rt_q    <= '0;
            rd_q    <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            rs_q    <= rs_d;
            rt_q    <= rt_d;
            rd_q    <= rd_d;
        end
    end

endmodule

// File: tb/tb_reg_read_issue.sv
// Directed, table-driven bench for reg_read_issue; expectations follow ISSUE_BYPASS_EN when defined.
module tb_reg_read_issue;

    logic        CLOCK_50;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_op;
    logic [4:0]  in_rs_addr;
    logic [4:0]  in_rt_addr;
    logic [4:0]  in_rd_addr;
    logic [15:0] in_imm;
    logic        in_use_imm;
    logic        wb_en;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [2:0]  ALU_OP;
    logic [31:0] rs;
    logic [31:0] rt;
    logic [4:0]  out_rd_addr;

    int checks = 0;
    int errors = 0;

    reg_read_issue dut (
        .CLOCK_50    (CLOCK_50),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_op       (in_op),
        .in_rs_addr  (in_rs_addr),
        .in_rt_addr  (in_rt_addr),
        .in_rd_addr  (in_rd_addr),
        .in_imm      (in_imm),
        .in_use_imm  (in_use_imm),
        .wb_en       (wb_en),
        .wb_addr     (wb_addr),
        .wb_data     (wb_data),
        .flush       (flush),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .ALU_OP      (ALU_OP),
        .rs          (rs),
        .rt          (rt),
        .out_rd_addr (out_rd_addr)
    );

    initial CLOCK_50 = 1'b0;
    always #10 CLOCK_50 = ~CLOCK_50;

    typedef struct {
        logic        v;
        logic [2:0]  op;
        logic [4:0]  ra;
        logic [4:0]  rb;
        logic [4:0]  rd;
        logic [15:0] imm;
        logic        ui;
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic        fl;
        logic        ordy;
        logic        e_ov;
        logic        e_ir;
        logic [2:0]  e_op;
        logic [31:0] e_rs;
        logic [31:0] e_rt;
        logic [4:0]  e_rd;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic v, logic [2:0] op, logic [4:0] ra, logic [4:0] rb, logic [4:0] rd,
                                logic [15:0] imm, logic ui, logic we, logic [4:0] wa, logic [31:0] wd,
                                logic fl, logic ordy, logic e_ov, logic e_ir, logic [2:0] e_op,
                                logic [31:0] e_rs, logic [31:0] e_rt, logic [4:0] e_rd);
        vec_t t;
        t.v = v; t.op = op; t.ra = ra; t.rb = rb; t.rd = rd; t.imm = imm; t.ui = ui;
        t.we = we; t.wa = wa; t.wd = wd; t.fl = fl; t.ordy = ordy;
        t.e_ov = e_ov; t.e_ir = e_ir; t.e_op = e_op; t.e_rs = e_rs; t.e_rt = e_rt; t.e_rd = e_rd;
        return t;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t t);
        in_valid   = t.v;
        in_op      = t.op;
        in_rs_addr = t.ra;
        in_rt_addr = t.rb;
        in_rd_addr = t.rd;
        in_imm     = t.imm;
        in_use_imm = t.ui;
        wb_en      = t.we;
        wb_addr    = t.wa;
        wb_data    = t.wd;
        flush      = t.fl;
        out_ready  = t.ordy;
    endtask

    task automatic check_outs(input string tag, input logic ov, input logic ir, input logic [2:0] op,
                              input logic [31:0] ers, input logic [31:0] ert, input logic [4:0] erd);
        chk({tag, ".out_valid"}, {31'd0, out_valid}, {31'd0, ov});
        chk({tag, ".in_ready"}, {31'd0, in_ready}, {31'd0, ir});
        chk({tag, ".ALU_OP"}, {29'd0, ALU_OP}, {29'd0, op});
        chk({tag, ".rs"}, rs, ers);
        chk({tag, ".rt"}, rt, ert);
        chk({tag, ".rd"}, {27'd0, out_rd_addr}, {27'd0, erd});
    endtask

    logic [31:0] byp;
    vec_t        idle;

    initial begin
`ifdef ISSUE_BYPASS_EN
        byp = 32'd9;
`else
        byp = 32'd0;
`endif
        idle = mk(0, 0, 0, 0, 0, 16'h0, 0, 0, 0, 32'h0, 0, 1, 0, 1, 0, 0, 0, 0);

        //             v op ra rb rd imm       ui we wa wd            fl ordy  ov ir op rs            rt            rd
        vecs.push_back(mk(0, 0, 0, 0, 0, 16'h0000, 0, 1, 1, 32'd7,        0, 1,  0, 1, 0, 32'd0,        32'd0,        0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 16'h0000, 0, 1, 2, 32'd5,        0, 1,  0, 1, 0, 32'd0,        32'd0,        0));
        vecs.push_back(mk(1, 0, 1, 2, 4, 16'h0000, 0, 0, 0, 32'd0,        0, 1,  1, 1, 0, 32'd7,        32'd5,        4));
        vecs.push_back(mk(0, 0, 0, 0, 0, 16'h0000, 0, 1, 0, 32'hFFFFFFFF, 0, 1,  0, 1, 0, 32'd7,        32'd5,        4));
        vecs.push_back(mk(1, 5, 0, 1, 3, 16'h0000, 0, 0, 0, 32'd0,        0, 1,  1, 1, 5, 32'd0,        32'd7,        3));
        vecs.push_back(mk(1, 2, 1, 0, 7, 16'hFFFE, 1, 0, 0, 32'd0,        0, 1,  1, 1, 2, 32'd7,        32'hFFFFFFFE, 7));
        vecs.push_back(mk(1, 1, 2, 0, 1, 16'h0005, 1, 0, 0, 32'd0,        0, 1,  1, 1, 1, 32'd5,        32'd5,        1));
        vecs.push_back(mk(1, 4, 3, 3, 2, 16'h0000, 0, 1, 3, 32'd9,        0, 1,  1, 1, 4, byp,          byp,          2));
        vecs.push_back(mk(1, 6, 3, 0, 5, 16'h0000, 0, 0, 0, 32'd0,        0, 1,  1, 1, 6, 32'd9,        32'd0,        5));
        vecs.push_back(mk(1, 3, 1, 2, 6, 16'h0000, 0, 0, 0, 32'd0,        0, 1,  1, 1, 3, 32'd7,        32'd5,        6));
        for (int k = 0; k < 5; k++)
            vecs.push_back(mk(1, 7, 2, 2, 9, 16'h0000, 0, 1, 1, 32'd100,  0, 0,  1, 0, 3, 32'd7,        32'd5,        6));
        vecs.push_back(mk(1, 7, 1, 2, 1, 16'h0000, 0, 0, 0, 32'd0,        0, 1,  1, 1, 7, 32'd100,      32'd5,        1));
        vecs.push_back(mk(1, 2, 2, 2, 2, 16'h0000, 0, 1, 5, 32'h55,       1, 0,  0, 1, 7, 32'd100,      32'd5,        1));
        vecs.push_back(mk(1, 1, 5, 0, 3, 16'h0000, 0, 0, 0, 32'd0,        0, 0,  1, 0, 1, 32'h55,       32'd0,        3));
        vecs.push_back(mk(0, 0, 0, 0, 0, 16'h0000, 0, 0, 0, 32'd0,        0, 1,  0, 1, 1, 32'h55,       32'd0,        3));

        drive(idle);
        out_ready = 1'b0;
        reset = 1'b1;
        repeat (2) @(posedge CLOCK_50);
        #1;
        reset = 1'b0;
        check_outs("rst", 0, 1, 0, 32'd0, 32'd0, 0);

        foreach (vecs[i]) begin
            drive(vecs[i]);
            @(posedge CLOCK_50);
            #1;
            check_outs($sformatf("v%0d", i), vecs[i].e_ov, vecs[i].e_ir, vecs[i].e_op,
                       vecs[i].e_rs, vecs[i].e_rt, vecs[i].e_rd);
        end

        // Reset (with flush and a write-back in the same cycle) while FULL.
        drive(mk(1, 2, 1, 2, 4, 16'h0, 0, 0, 0, 32'd0, 0, 0, 0, 0, 0, 0, 0, 0));
        @(posedge CLOCK_50);
        #1;
        check_outs("pre_rst", 1, 0, 2, 32'd100, 32'd5, 4);
        drive(mk(1, 5, 1, 2, 6, 16'h0, 0, 1, 6, 32'h66, 1, 0, 0, 0, 0, 0, 0, 0));
        reset = 1'b1;
        @(posedge CLOCK_50);
        #1;
        reset = 1'b0;
        drive(idle);
        check_outs("mid_rst", 0, 1, 0, 32'd0, 32'd0, 0);
        drive(mk(1, 3, 1, 6, 2, 16'h0, 0, 0, 0, 32'd0, 0, 1, 0, 0, 0, 0, 0, 0));
        @(posedge CLOCK_50);
        #1;
        check_outs("post_rst", 1, 1, 3, 32'd0, 32'd0, 2);
        drive(idle);
        @(posedge CLOCK_50);
        #1;
        chk("drain.out_valid", {31'd0, out_valid}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
